// File: rtl/irq_timer256_ctrl.sv
// Interrupt capture and arbitration for the four 256 Hz timer sources.
// Sticky pending flags, enable/priority masking, registered CPU request.
module irq_timer256_ctrl #(
    parameter logic [7:0]  VECTOR_BASE = 8'h14,
    parameter logic [23:0] REG_PRIO    = 24'h2022,
    parameter logic [23:0] REG_ENABLE  = 24'h2028,
    parameter logic [23:0] REG_PENDING = 24'h2029
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic [3:0]  irqs_in,
    input  logic        cpu_irq_ack,
    output logic        irq_req,
    output logic [7:0]  irq_vector,
    output logic [1:0]  irq_priority
);

    logic [3:0] sync1_q, sync2_q, sync3_q;
    logic [1:0] arm_q;
    logic [3:0] rise;
    logic [3:0] cap_q, cap_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] en_q, en_d;
    logic [1:0] prio_q, prio_d;
    logic       req_q, req_d;
    logic [7:0] vec_q, vec_d;
    logic [1:0] win_q, win_d;
    logic [1:0] lvl_q, lvl_d;

    logic [3:0] active;
    logic [1:0] winner;
    logic       valid;
    logic       wr_prio, wr_en, wr_pend;
    logic       ack_ok;
    logic [3:0] ack_mask;
    logic [3:0] w1c_mask;
    logic       unused_bits;

    assign unused_bits = ^{bus_read, bus_data_in[7:4]};

    // Edge detection stays masked until the synchronizer has refilled after
    // reset, so a level held through reset is not mistaken for a new edge.
    assign rise = (arm_q == 2'd3) ? (sync2_q & ~sync3_q) : 4'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 4'd0;
            sync2_q <= 4'd0;
            sync3_q <= 4'd0;
            arm_q   <= 2'd0;
            cap_q   <= 4'd0;
        end else begin
            sync1_q <= irqs_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (arm_q != 2'd3) begin
                arm_q <= arm_q + 2'd1;
            end
            cap_q <= cap_d;
        end
    end

    assign cap_d = (clk_ce ? 4'd0 : cap_q) | rise;

    assign wr_prio = clk_ce && bus_write && (bus_address_in == REG_PRIO);
    assign wr_en   = clk_ce && bus_write && (bus_address_in == REG_ENABLE);
    assign wr_pend = clk_ce && bus_write && (bus_address_in == REG_PENDING);

    assign ack_ok   = cpu_irq_ack && req_q;
    assign ack_mask = ack_ok ? (4'b0001 << win_q) : 4'd0;
    assign w1c_mask = wr_pend ? bus_data_in[3:0] : 4'd0;

    assign active = pend_q & en_q;
    assign valid  = (active != 4'd0) && (prio_q != 2'd0);

    always_comb begin
        winner = 2'd0;
        if (active[3]) begin
            winner = 2'd3;
        end else if (active[2]) begin
            winner = 2'd2;
        end else if (active[1]) begin
            winner = 2'd1;
        end
    end

    always_comb begin
        pend_d = pend_q;
        en_d   = en_q;
        prio_d = prio_q;
        req_d  = req_q;
        vec_d  = vec_q;
        win_d  = win_q;
        lvl_d  = lvl_q;
        if (clk_ce) begin
            // A captured edge wins over any clear in the same cycle.
            pend_d = (pend_q & ~w1c_mask & ~ack_mask) | cap_q;
            req_d  = valid;
            lvl_d  = valid ? prio_q : 2'd0;
            if (valid) begin
                win_d = winner;
                vec_d = VECTOR_BASE + {6'd0, winner};
            end
        end
        if (wr_en) begin
            en_d = bus_data_in[3:0];
        end
        if (wr_prio) begin
            prio_d = bus_data_in[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= 4'd0;
            en_q   <= 4'd0;
            prio_q <= 2'd0;
            req_q  <= 1'b0;
            vec_q  <= VECTOR_BASE;
            win_q  <= 2'd0;
            lvl_q  <= 2'd0;
        end else begin
            pend_q <= pend_d;
            en_q   <= en_d;
            prio_q <= prio_d;
            req_q  <= req_d;
            vec_q  <= vec_d;
            win_q  <= win_d;
            lvl_q  <= lvl_d;
        end
    end

    always_comb begin
        bus_data_out = 8'd0;
        if (bus_address_in == REG_PRIO) begin
            bus_data_out = {6'd0, prio_q};
        end else if (bus_address_in == REG_ENABLE) begin
            bus_data_out = {4'd0, en_q};
        end else if (bus_address_in == REG_PENDING) begin
            bus_data_out = {4'd0, pend_q};
        end
    end

    assign irq_req      = req_q;
    assign irq_vector   = vec_q;
    assign irq_priority = lvl_q;

endmodule

// File: tb/tb_irq_timer256_ctrl.sv
// Bench for irq_timer256_ctrl: vector table plus hand-written
// sequences for set/clear collision, sparse clk_ce and reset.
module tb_irq_timer256_ctrl;

    localparam logic [23:0] A_PRIO = 24'h2022;
    localparam logic [23:0] A_EN   = 24'h2028;
    localparam logic [23:0] A_PEND = 24'h2029;
    localparam logic [23:0] A_NONE = 24'h2023;

    logic        clk;
    logic        rst_n;
    logic        clk_ce;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic [3:0]  irqs_in;
    logic        cpu_irq_ack;
    logic        irq_req;
    logic [7:0]  irq_vector;
    logic [1:0]  irq_priority;

    irq_timer256_ctrl dut (
        .clk            (clk),
        .reset          (rst_n),
        .clk_ce         (clk_ce),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .irqs_in        (irqs_in),
        .cpu_irq_ack    (cpu_irq_ack),
        .irq_req        (irq_req),
        .irq_vector     (irq_vector),
        .irq_priority   (irq_priority)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [3:0]  pulse;
        logic        ack;
        int          waitc;
        logic [23:0] raddr;
        logic [7:0]  rd;
        logic        req;
        logic [7:0]  vec;
        logic [1:0]  pri;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] rd;
        logic       req;
        logic [7:0] vec;
        logic [1:0] pri;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic vec_t mk(string nm, logic wr, logic [23:0] a,
                                logic [7:0] d, logic [3:0] p, logic ak,
                                int w, logic [23:0] ra, logic [7:0] rd,
                                logic rq, logic [7:0] vc, logic [1:0] pr);
        vec_t v;
        v.name = nm; v.wr = wr; v.addr = a; v.wdata = d;
        v.pulse = p; v.ack = ak; v.waitc = w; v.raddr = ra;
        v.rd = rd; v.req = rq; v.vec = vc; v.pri = pr;
        return v;
    endfunction

    task automatic chk(string nm, string fld, logic [7:0] act,
                       logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    task automatic expect_out(string nm, logic [7:0] rd, logic rq,
                              logic [7:0] vc, logic [1:0] pr);
        exp_t e;
        e.name = nm; e.rd = rd; e.req = rq; e.vec = vc; e.pri = pr;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: empty at sample time");
            return;
        end
        e = sb.pop_front();
        chk(e.name, "rd", bus_data_out, e.rd);
        chk(e.name, "req", {7'd0, irq_req}, {7'd0, e.req});
        chk(e.name, "vec", irq_vector, e.vec);
        chk(e.name, "pri", {6'd0, irq_priority}, {6'd0, e.pri});
    endtask

    task automatic apply(vec_t v);
        @(posedge clk); #1;
        bus_write = v.wr;
        bus_address_in = v.addr;
        bus_data_in = v.wdata;
        cpu_irq_ack = v.ack;
        irqs_in = v.pulse;
        @(posedge clk); #1;
        bus_write = 1'b0;
        cpu_irq_ack = 1'b0;
        @(posedge clk); #1;
        irqs_in = 4'd0;
        repeat (v.waitc) @(posedge clk);
        #1;
        bus_address_in = v.raddr;
        expect_out(v.name, v.rd, v.req, v.vec, v.pri);
        @(negedge clk);
        sample();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clk_ce = 1'b1;
        rst_n = 1'b0;
        bus_write = 1'b0;
        bus_read = 1'b0;
        bus_address_in = 24'd0;
        bus_data_in = 8'd0;
        irqs_in = 4'd0;
        cpu_irq_ack = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            irqs_in = 4'($urandom_range(0, 15));
        end
        bus_address_in = A_PEND;
        expect_out("in_reset", 8'h00, 1'b0, 8'h14, 2'd0);
        sample();
        irqs_in = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 irqs_in = 4'd0;
        repeat (4) @(posedge clk);
        #1 bus_address_in = A_PRIO;
        expect_out("rst_prio", 8'h00, 1'b0, 8'h14, 2'd0);
        @(negedge clk); sample();
        bus_address_in = A_EN;
        expect_out("rst_en", 8'h00, 1'b0, 8'h14, 2'd0);
        @(negedge clk); sample();
        bus_address_in = A_PEND;
        expect_out("rst_pend", 8'h00, 1'b0, 8'h14, 2'd0);
        @(negedge clk); sample();

        tbl.push_back(mk("en_f",     1, A_EN,   8'h0F, 4'h0, 0, 0, A_EN,   8'h0F, 0, 8'h14, 2'd0));
        tbl.push_back(mk("prio_2",   1, A_PRIO, 8'hFE, 4'h0, 0, 0, A_PRIO, 8'h02, 0, 8'h14, 2'd0));
        tbl.push_back(mk("pulse_b1", 0, A_NONE, 8'h00, 4'h2, 0, 4, A_PEND, 8'h02, 1, 8'h15, 2'd2));
        tbl.push_back(mk("ack_b1",   0, A_NONE, 8'h00, 4'h0, 1, 0, A_PEND, 8'h00, 0, 8'h15, 2'd0));
        tbl.push_back(mk("prio_1",   1, A_PRIO, 8'h01, 4'h0, 0, 0, A_PRIO, 8'h01, 0, 8'h15, 2'd0));
        tbl.push_back(mk("pulse_b30",0, A_NONE, 8'h00, 4'h9, 0, 4, A_PEND, 8'h09, 1, 8'h17, 2'd1));
        tbl.push_back(mk("ack_b3",   0, A_NONE, 8'h00, 4'h0, 1, 0, A_PEND, 8'h01, 1, 8'h14, 2'd1));
        tbl.push_back(mk("ack_b0",   0, A_NONE, 8'h00, 4'h0, 1, 0, A_PEND, 8'h00, 0, 8'h14, 2'd0));
        tbl.push_back(mk("prio_0",   1, A_PRIO, 8'h00, 4'h0, 0, 0, A_PRIO, 8'h00, 0, 8'h14, 2'd0));
        tbl.push_back(mk("pulse_b2", 0, A_NONE, 8'h00, 4'h4, 0, 4, A_PEND, 8'h04, 0, 8'h14, 2'd0));
        tbl.push_back(mk("prio_3",   1, A_PRIO, 8'h03, 4'h0, 0, 0, A_PEND, 8'h04, 1, 8'h16, 2'd3));
        tbl.push_back(mk("en_0",     1, A_EN,   8'h00, 4'h0, 0, 0, A_EN,   8'h00, 0, 8'h16, 2'd0));
        tbl.push_back(mk("w1c_b2",   1, A_PEND, 8'h04, 4'h0, 0, 0, A_PEND, 8'h00, 0, 8'h16, 2'd0));
        tbl.push_back(mk("rd_other", 0, A_NONE, 8'h00, 4'h0, 0, 0, A_NONE, 8'h00, 0, 8'h16, 2'd0));
        tbl.push_back(mk("en_ff",    1, A_EN,   8'hFF, 4'h0, 0, 0, A_EN,   8'h0F, 0, 8'h16, 2'd0));
        tbl.push_back(mk("dis_b3",   1, A_EN,   8'h00, 4'h8, 0, 4, A_PEND, 8'h08, 0, 8'h16, 2'd0));
        tbl.push_back(mk("ack_noreq",0, A_NONE, 8'h00, 4'h0, 1, 0, A_PEND, 8'h08, 0, 8'h16, 2'd0));
        tbl.push_back(mk("en_b3",    1, A_EN,   8'h0F, 4'h0, 0, 0, A_EN,   8'h0F, 1, 8'h17, 2'd3));
        tbl.push_back(mk("w1c_all",  1, A_PEND, 8'h0F, 4'h0, 0, 0, A_PEND, 8'h00, 0, 8'h17, 2'd0));

        foreach (tbl[i]) apply(tbl[i]);

        // W1C on the same clk_ce that consumes a captured bit-0 edge.
        @(posedge clk); #1;
        irqs_in = 4'h1;
        @(posedge clk);
        @(posedge clk); #1;
        irqs_in = 4'h0;
        @(posedge clk); #1;
        bus_write = 1'b1;
        bus_address_in = A_PEND;
        bus_data_in = 8'h01;
        @(posedge clk); #1;
        bus_write = 1'b0;
        expect_out("w1c_collide", 8'h01, 1'b0, 8'h17, 2'd0);
        @(negedge clk); sample();
        @(posedge clk); #1;
        bus_write = 1'b1;
        @(posedge clk); #1;
        bus_write = 1'b0;
        expect_out("w1c_again", 8'h00, 1'b1, 8'h14, 2'd3);
        @(negedge clk); sample();
        @(posedge clk); #1;
        expect_out("w1c_drop", 8'h00, 1'b0, 8'h14, 2'd0);
        @(negedge clk); sample();

        // clk_ce every 4th clk, bit-2 pulse lands between enables.
        @(posedge clk); #1;
        bus_address_in = A_PEND;
        for (int k = 0; k <= 16; k++) begin
            clk_ce = (k % 4 == 3);
            irqs_in = (k == 5 || k == 6) ? 4'h4 : 4'h0;
            if (k == 11) begin
                expect_out("ce_hold", 8'h00, 1'b0, 8'h14, 2'd0);
                @(negedge clk); sample();
            end
            if (k == 12) begin
                expect_out("ce_pend", 8'h04, 1'b0, 8'h14, 2'd0);
                @(negedge clk); sample();
            end
            if (k == 16) begin
                expect_out("ce_req", 8'h04, 1'b1, 8'h16, 2'd3);
                @(negedge clk); sample();
            end
            @(posedge clk); #1;
        end
        clk_ce = 1'b1;
        irqs_in = 4'h0;

        // Reset while a request is up drops it without waiting for a clock.
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst_mid", 8'h00, 1'b0, 8'h14, 2'd0);
        sample();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_timer256_ctrl.md
# irq_timer256_ctrl

Interrupt capture and arbitration stage for the four 256 Hz timer interrupt sources. It takes the one-cycle `rt_clk`-domain interrupt pulses produced by the 256 Hz timer and latches them into sticky pending flags. It masks them with software-visible enable and priority registers and presents a single registered request, vector and priority level to the CPU core, which acknowledges it. It sits between the 256 Hz timer and the CPU interrupt input, on the shared system bus.

## Interface
Parameters:
- `VECTOR_BASE`, 8'h14: vector number of source 0; source n uses `VECTOR_BASE + n`.
- `REG_PRIO`, 24'h2022: address of the priority register.
- `REG_ENABLE`, 24'h2028: address of the enable register.
- `REG_PENDING`, 24'h2029: address of the pending register.

Ports:
- `clk` in 1: system clock, the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `clk_ce` in 1: clock enable; all architectural state advances only when high.
- `bus_write` in 1: bus write strobe.
- `bus_read` in 1: bus read strobe (informational; reads have no side effects).
- `bus_address_in` in 24: bus address.
- `bus_data_in` in 8: bus write data.
- `bus_data_out` out 8: combinational read data.
- `irqs_in` in 4: timer interrupt pulses from the `rt_clk` domain, asynchronous to `clk`. Bit 3 is the 8-bit wrap, bit 2 is the 128 tick, bit 1 is the 32 tick and bit 0 is the 8 tick.
- `cpu_irq_ack` in 1: CPU accepts the currently presented `irq_vector`.
- `irq_req` out 1: registered interrupt request.
- `irq_vector` out 8: registered vector of the winning source.
- `irq_priority` out 2: registered priority level of the request.

## Operation
- Synchronizer:
  - Each `irqs_in` bit passes through a 2-flop synchronizer clocked on every `clk`, without `clk_ce` gating.
  - A rising-edge detector follows the synchronizer.
  - A detected edge sets a per-bit capture flop. The capture flop holds until it is consumed on the next `clk_ce` cycle, so an edge is never lost between enables.
- Pending register (4 bits, sticky). On each `clk_ce` cycle, in this order:
  - Clear sources:
    - a write to `REG_PENDING` clears every bit written as 1 (write-1-to-clear);
    - `cpu_irq_ack` clears the bit of the source currently shown on `irq_vector`.
  - Set source: a captured edge sets its bit. Set has priority over any clear in the same cycle.
  - Pending bits latch regardless of enable or priority; those registers only gate the request.
- Enable register (bits 3:0) and priority register (bits 1:0) are written on a `clk_ce` cycle with `bus_write` high and a matching address. Unused bits are ignored on write and read as 0.
- Arbitration:
  - `active = pending & enable`.
  - The winner is the highest set index of `active`, so bit 3 has the highest priority.
  - The request is valid when `active != 0` and `priority != 0`.
- Outputs, registered on `clk_ce`:
  - `irq_req` equals request valid.
  - `irq_vector` equals `VECTOR_BASE + winner`. It holds its last value when there is no request.
  - `irq_priority` equals the priority register while a request is valid, otherwise 0.
- Handshake:
  - `cpu_irq_ack` is honoured only while `irq_req` is high; otherwise it is ignored.
  - The CPU must hold `cpu_irq_ack` for exactly one `clk_ce` cycle.
- Read mux:
  - `REG_PRIO` returns `{6'd0, prio}`.
  - `REG_ENABLE` returns `{4'd0, enable}`.
  - `REG_PENDING` returns `{4'd0, pending}`.
  - Any other address returns 0.

## Timing
- Reset (asynchronous assert, synchronous release on `clk`): pending, enable, priority, capture and synchronizer flops are 0. `irq_req` is 0, `irq_priority` is 0 and `irq_vector` is `VECTOR_BASE`.
- An edge arriving mid-reset is discarded.
- A reset mid-request drops `irq_req` immediately.
- Edge to pending: the synchronized edge is captured at the 3rd `clk` edge after the `irqs_in` rise. Pending sets on the first `clk_ce` at or after capture.
- Pending to `irq_req`: one further `clk_ce` cycle.
- With `clk_ce` tied high, `irqs_in` rise to `irq_req` is 4–5 `clk` cycles.
- Ack to deassertion: pending clears on the ack `clk_ce` edge. `irq_req` and `irq_vector` update on the next `clk_ce`, showing the next winner or dropping the request.
- A register write affects `irq_req` on the `clk_ce` after the write.
- An `irqs_in` pulse must be at least 2 `clk` periods wide. The `rt_clk` period guarantees this.
- Repeated edges on an already-pending bit merge into one pending event; there is no counting.

## Test plan
- Reset with `irqs_in` toggling: all registers read 0; `irq_req=0`; `irq_vector=8'h14`.
- Enable=4'hF, prio=2, pulse bit 1: `irq_req=1`, `irq_vector=8'h15`, `irq_priority=2`. After `cpu_irq_ack`, pending reads 0 and `irq_req` drops on the next `clk_ce`.
- Pulse bits 0 and 3 together with enable=4'hF, prio=1:
  - vector 8'h17 is presented first;
  - after ack, vector 8'h14 is presented;
  - after a second ack, `irq_req=0`.
- Prio=0 or enable=0, pulse bit 2: pending reads 4'h4 and `irq_req` stays 0. Then writing prio=3 makes `irq_req=1`, `irq_vector=8'h16` one `clk_ce` later.
- Write-1-to-clear 4'h1 on `REG_PENDING` in the same `clk_ce` as a captured bit-0 edge: pending bit 0 stays 1. Writing 4'h1 again later clears it.
- `clk_ce` asserted only every 4th `clk` with a 2-`clk` `irqs_in` pulse between enables: the event is still captured and pending reads 1.
